mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Streaming encoder that turns ALU-operation requests, using the same 4-bit ALUop codes the control unit decodes, back into 32-bit MIPS R-type and I-type instruction words. It is the inverse of the ALU decode path. It sits between the test-program generator and instruction-memory preload, and emits one word per handshake with a sequential byte address. A 2-entry output FIFO decouples the request and instruction handshakes, and illegal requests are dropped and counted.

## Interface
- `ADDR_W`, default 10: width of the instruction byte address.
- `BASE_ADDR`, default 0: address of the first emitted word; must be 4-aligned.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous; empties the FIFO, reloads the address to `BASE_ADDR`, and zeroes `err_count`.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_kind` input 2: 0 R-ALU, 1 I-ALU, 2 JR, 3 SYSCALL.
- `req_aluop` input 4: ALUop code.
- `req_unsigned` input 1: with I-ALU add, selects addiu instead of addi.
- `req_rs`, `req_rt`, `req_rd`, `req_shamt` input 5 each: register and shift fields.
- `req_imm` input 16: immediate.
- `instr_valid` output 1: FIFO head valid.
- `instr_ready` input 1: consumer accepts the FIFO head.
- `instr` output 32: encoded word.
- `instr_addr` output ADDR_W: byte address of `instr`.
- `err` output 1: one-cycle pulse per dropped illegal request.
- `err_count` output 8: saturating count of dropped requests.

## Operation
- R-ALU, opcode 000000, fields {rs,rt,rd,shamt,funct}:
  - ALUop 0101 encodes add, funct 100000. 0110 encodes sub, 100010. 0111 encodes and, 100100. 1000 encodes or, 100101. 1010 encodes nor, 100111. 1011 encodes slt, 101010. 1100 encodes sltu, 101011.
  - Shifts: 0000 encodes sll, funct 000000. 0010 encodes srl, 000010. 0001 encodes sra, 000011.
  - For shifts, rs is forced to 0 and shamt is taken from `req_shamt`. For all non-shifts, shamt is forced to 0.
- I-ALU, fields {op,rs,rt,imm}:
  - 0101 encodes addi, op 001000, or addiu, op 001001, when `req_unsigned` is 1.
  - 0111 encodes andi, 001100. 1000 encodes ori, 001101. 1011 encodes slti, 001010. 1100 encodes sltiu, 001011.
- JR encodes op 0, rs=`req_rs`, funct 001000; every other field is 0. `req_aluop` is ignored.
- SYSCALL encodes 0x0000000C. Every request field is ignored.
- Illegal requests: any other ALUop for the kind, e.g. I-ALU with 0110.
  - The request is still accepted, so the handshake completes.
  - Nothing is pushed and the address does not advance.
  - `err` pulses in the next cycle and `err_count` increments, saturating at 255.
- Each legal accepted request pushes {word, addr} into the FIFO. The address register then advances by 4 and wraps modulo 2^ADDR_W.
- Reset values: FIFO empty, `instr_valid`=0, `instr`=0, `instr_addr`=`BASE_ADDR`, `req_ready`=1, `err`=0, `err_count`=0.

## Timing
- Latency: a request accepted in cycle N becomes visible on `instr`/`instr_valid` in N+1, provided nothing is ahead of it in the FIFO.
- `req_ready` = (FIFO count < 2). It is registered, with no combinational path from `instr_ready`. At count 2 with a pop in the same cycle, `req_ready` still reads 0 that cycle and rises in the next.
- Push and pop in the same cycle at count 1 keep the count at 1, and the new word becomes the head.
- The head holds stable while `instr_valid`=1 and `instr_ready`=0. The consumer may not see it change until it is popped.
- `clear` has priority over a simultaneous handshake. The accepted request is discarded, with no push and no `err`.
- An `rst_n` assertion mid-stream drops the FIFO contents immediately and asynchronously. Outputs return to their reset values.

## Structure
- Shared package `mips_pkg` holds:
  - ALUop localparams, e.g. `ALU_ADD`=4'b0101.
  - Opcode and funct localparams.
  - The `req_kind` enum.
  - A `encoded_t` struct: {legal, word}.
- Sub-module `mips_encode_comb` is purely combinational: request fields in, {legal, word} out.
- The top level holds the 2-entry FIFO, the address counter and the error counter.

## Test plan
- Legal encodes, with reset, then `instr_ready`=1:
  - R-ALU add, rs=1 rt=2 rd=3 -> `instr`=0x00221820, addr 0.
  - I-ALU ori, rs=0 rt=5 imm=0x1234 -> `instr`=0x34051234, addr 4.
- Shifts, jr and syscall:
  - sra rt=4 rd=4 shamt=2 -> 0x00042083.
  - jr rs=31 -> 0x03E00008.
  - syscall -> 0x0000000C.
- Backpressure: hold `instr_ready`=0 and send 3 requests.
  - `req_ready` drops after 2 are accepted.
  - The head holds the first word.
  - Release -> words drain in order with addrs 0, 4, 8.
- Illegal: I-ALU with ALUop 0110.
  - The request is accepted, `err` pulses once and `err_count`=1.
  - No `instr_valid`; the next legal word gets the unchanged address.
- Wrap and clear, with ADDR_W=4:
  - 5 legal words -> addresses 0, 4, 8, 12, 0.
  - `clear` together with a valid request -> FIFO empty, address = `BASE_ADDR`, no push.
- Reset mid-stream: assert `rst_n`=0 with 2 words queued -> `instr_valid` goes low immediately and `err_count`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS instruction encoder: ALUop codes, opcodes, funct codes,
// the request-kind enum and the {legal, word} result struct.
package mips_pkg;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRA  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

    typedef enum logic [1:0] {
        KIND_RALU    = 2'd0,
        KIND_IALU    = 2'd1,
        KIND_JR      = 2'd2,
        KIND_SYSCALL = 2'd3
    } req_kind_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } encoded_t;

endpackage

// File: rtl/mips_encode_comb.sv
// Combinational encoder: request fields in, {legal, word} out, zero latency.
// Illegal ALUop/kind combinations return legal=0 with a zero word.
module mips_encode_comb
    import mips_pkg::*;
(
    input  req_kind_t  kind,
    input  logic [3:0] aluop,
    input  logic       is_unsigned,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic [4:0] shamt,
    input  logic [15:0] imm,
    output encoded_t   enc
);

    logic [5:0] funct;
    logic [5:0] opcode;
    logic       is_shift;

    always_comb begin
        enc      = '0;
        funct    = '0;
        opcode   = '0;
        is_shift = 1'b0;
        case (kind)
            KIND_RALU: begin
                enc.legal = 1'b1;
                case (aluop)
                    ALU_ADD:  funct = FN_ADD;
                    ALU_SUB:  funct = FN_SUB;
                    ALU_AND:  funct = FN_AND;
                    ALU_OR:   funct = FN_OR;
                    ALU_NOR:  funct = FN_NOR;
                    ALU_SLT:  funct = FN_SLT;
                    ALU_SLTU: funct = FN_SLTU;
                    ALU_SLL:  begin funct = FN_SLL; is_shift = 1'b1; end
                    ALU_SRL:  begin funct = FN_SRL; is_shift = 1'b1; end
                    ALU_SRA:  begin funct = FN_SRA; is_shift = 1'b1; end
                    default:  enc.legal = 1'b0;
                endcase
                // Shifts take their amount from shamt and have no rs source.
                if (enc.legal) begin
                    enc.word = {OP_RTYPE, is_shift ? 5'd0 : rs, rt, rd,
                                is_shift ? shamt : 5'd0, funct};
                end
            end
            KIND_IALU: begin
                enc.legal = 1'b1;
                case (aluop)
                    ALU_ADD:  opcode = is_unsigned ? OP_ADDIU : OP_ADDI;
                    ALU_AND:  opcode = OP_ANDI;
                    ALU_OR:   opcode = OP_ORI;
                    ALU_SLT:  opcode = OP_SLTI;
                    ALU_SLTU: opcode = OP_SLTIU;
                    default:  enc.legal = 1'b0;
                endcase
                if (enc.legal) begin
                    enc.word = {opcode, rs, rt, imm};
                end
            end
            KIND_JR: begin
                enc.legal = 1'b1;
                enc.word  = {OP_RTYPE, rs, 15'd0, FN_JR};
            end
            default: begin
                enc.legal = 1'b1;
                enc.word  = SYSCALL_WORD;
            end
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming ALU-request -> MIPS word encoder with sequential byte addresses; 1-cycle latency
// through a 2-entry FIFO. req_ready is registered (count<2); illegal requests are consumed and counted.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [3:0]        req_aluop,
    input  logic              req_unsigned,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    encoded_t          enc;
    logic [31:0]       word_mem [2];
    logic [ADDR_W-1:0] addr_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count_q;
    logic [1:0]        count_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;

    mips_encode_comb u_enc (
        .kind        (req_kind_t'(req_kind)),
        .aluop       (req_aluop),
        .is_unsigned (req_unsigned),
        .rs          (req_rs),
        .rt          (req_rt),
        .rd          (req_rd),
        .shamt       (req_shamt),
        .imm         (req_imm),
        .enc         (enc)
    );

    assign accept      = req_valid & req_ready;
    assign push        = accept & enc.legal & ~clear;
    assign drop        = accept & ~enc.legal & ~clear;
    assign pop         = instr_valid & instr_ready;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = word_mem[rd_ptr];
    assign instr_addr  = addr_mem[rd_ptr];

    always_comb begin
        count_nxt = count_q;
        if (clear) begin
            count_nxt = 2'd0;
        end else if (push && !pop) begin
            count_nxt = count_q + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            req_ready   <= 1'b1;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            word_mem[0] <= '0;
            word_mem[1] <= '0;
            addr_mem[0] <= BASE;
            addr_mem[1] <= BASE;
            addr_q      <= BASE;
            err         <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            count_q   <= count_nxt;
            // Registered from next count so a pop at full only reopens the next cycle.
            req_ready <= (count_nxt < 2'd2);
            err       <= drop;
            if (clear) begin
                wr_ptr    <= 1'b0;
                rd_ptr    <= 1'b0;
                addr_q    <= BASE;
                err_count <= 8'd0;
            end else begin
                if (push) begin
                    word_mem[wr_ptr] <= enc.word;
                    addr_mem[wr_ptr] <= addr_q;
                    wr_ptr           <= ~wr_ptr;
                    addr_q           <= addr_q + ADDR_W'(4);
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                if (drop && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed-vector bench for mips_instr_encoder (ADDR_W=4 so the address wrap is reachable).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = 2'd0;
    logic [3:0]  req_aluop = 4'd0;
    logic        req_unsigned = 1'b0;
    logic [4:0]  req_rs = 5'd0;
    logic [4:0]  req_rt = 5'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [4:0]  req_shamt = 5'd0;
    logic [15:0] req_imm = 16'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [3:0]  instr_addr;
    logic        err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_aluop    (req_aluop),
        .req_unsigned (req_unsigned),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_rd       (req_rd),
        .req_shamt    (req_shamt),
        .req_imm      (req_imm),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_addr   (instr_addr),
        .err          (err),
        .err_count    (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] k, input logic [3:0] op, input logic u,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [4:0] sh, input logic [15:0] imm);
        req_kind     = k;
        req_aluop    = op;
        req_unsigned = u;
        req_rs       = rs;
        req_rt       = rt;
        req_rd       = rd;
        req_shamt    = sh;
        req_imm      = imm;
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic send(input logic [1:0] k, input logic [3:0] op, input logic u,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [15:0] imm);
        int n = 0;
        set_req(k, op, u, rs, rt, rd, sh, imm);
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("send_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] w, input logic [3:0] a);
        chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
        chk({tag, "_word"}, instr, w);
        chk({tag, "_addr"}, 32'(instr_addr), 32'(a));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_vld", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", 32'(instr_addr), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Legal encodes, consumer always ready; fifth word wraps the 4-bit address.
        instr_ready = 1'b1;
        send(2'd0, 4'b0101, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        head("add", 32'h0022_1820, 4'd0);
        send(2'd1, 4'b1000, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234);
        head("ori", 32'h3405_1234, 4'd4);
        send(2'd0, 4'b0001, 1'b0, 5'd0, 5'd4, 5'd4, 5'd2, 16'h0);
        head("sra", 32'h0004_2083, 4'd8);
        send(2'd2, 4'b1111, 1'b0, 5'd31, 5'd7, 5'd7, 5'd7, 16'hFFFF);
        head("jr", 32'h03E0_0008, 4'd12);
        send(2'd3, 4'b1111, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 16'hABCD);
        head("syscall_wrap", 32'h0000_000C, 4'd0);
        send(2'd1, 4'b0101, 1'b1, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
        head("addiu", 32'h2422_FFFF, 4'd4);
        send(2'd0, 4'b0000, 1'b0, 5'd7, 5'd1, 5'd2, 5'd31, 16'h0);
        head("sll_rs0", 32'h0001_17C0, 4'd8);
        send(2'd0, 4'b0101, 1'b0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0);
        head("add_sh0", 32'h0022_1820, 4'd12);
        @(negedge clk);
        chk("drained", 32'(instr_valid), 32'd0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Backpressure: two fill the FIFO, third waits.
        instr_ready = 1'b0;
        send(2'd0, 4'b0101, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        send(2'd0, 4'b1000, 1'b0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0);
        chk("bp_full_rdy", 32'(req_ready), 32'd0);
        head("bp_head", 32'h0022_1820, 4'd0);
        set_req(2'd1, 4'b0111, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF);
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_hold_rdy", 32'(req_ready), 32'd0);
        head("bp_hold", 32'h0022_1820, 4'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_reopen", 32'(req_ready), 32'd1);
        head("bp_b", 32'h0085_3025, 4'd4);
        @(negedge clk);
        req_valid = 1'b0;
        head("bp_c", 32'h3022_00FF, 4'd8);
        @(negedge clk);
        chk("bp_empty", 32'(instr_valid), 32'd0);

        // Illegal request: consumed, counted, no push, address unchanged.
        send(2'd1, 4'b0110, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_cnt", 32'(err_count), 32'd1);
        chk("ill_novld", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("ill_err_pulse", 32'(err), 32'd0);
        send(2'd0, 4'b1011, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        head("slt_after_ill", 32'h0022_182A, 4'd12);
        @(negedge clk);
        send(2'd0, 4'b1111, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        chk("ill_r_cnt", 32'(err_count), 32'd2);

        // Clear wins over a simultaneous legal handshake.
        instr_ready = 1'b0;
        send(2'd0, 4'b0110, 1'b0, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0);
        head("sub", 32'h0109_5022, 4'd0);
        set_req(2'd0, 4'b0110, 1'b0, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0);
        req_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        req_valid = 1'b0;
        chk("clr_vld", 32'(instr_valid), 32'd0);
        chk("clr_errcnt", 32'(err_count), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        instr_ready = 1'b1;
        send(2'd3, 4'b0000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        head("clr_base", 32'h0000_000C, 4'd0);
        @(negedge clk);

        // Error counter saturates.
        for (int i = 0; i < 260; i++) begin
            send(2'd1, 4'b1010, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        end
        chk("err_sat", 32'(err_count), 32'd255);

        // Asynchronous reset with two words queued.
        instr_ready = 1'b0;
        send(2'd0, 4'b0111, 1'b0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0);
        send(2'd0, 4'b1010, 1'b0, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0);
        chk("pre_rst_vld", 32'(instr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(instr_valid), 32'd0);
        chk("arst_errcnt", 32'(err_count), 32'd0);
        chk("arst_rdy", 32'(req_ready), 32'd1);
        chk("arst_instr", instr, 32'd0);
        chk("arst_addr", 32'(instr_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
